// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: load bus, control inputs and issued-instruction outputs of the fetch unit
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              stall;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              branch_eq;
  logic [31:0]       instrword;
  logic              newinstr;
  logic [31:0]       pc;
  logic              busy;
  logic              halted;
  modport master (
    output start, stall, load_en, load_addr, load_data, branch_eq,
    input  instrword, newinstr, pc, busy, halted
  );
  modport slave (
    input  start, stall, load_en, load_addr, load_data, branch_eq,
    output instrword, newinstr, pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, loadable imem and j/beq/bne/halt sequencing feeding mipscpu one instruction at a time
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH       = 128,
  parameter int          ADDR_W           = 7,
  parameter int          CYCLES_PER_INSTR = 6,
  parameter logic [31:0] RESET_PC         = 32'h0,
  parameter logic [5:0]  HALT_OP          = 6'h3F
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_fetch_unit_if.slave    bus
);
  localparam int CW = (CYCLES_PER_INSTR > 2) ? $clog2(CYCLES_PER_INSTR) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, HALT} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d, instr_q, instr_d;
  logic            newinstr_q, newinstr_d, busy_q, busy_d, halted_q, halted_d;
  logic [31:0]     mem [IMEM_DEPTH];
  logic            wr, fetch, at_rest, last, oor, taken;
  logic [5:0]      op;
  logic [31:0]     pc4, npc, target, word;
  logic [ADDR_W-1:0] idx;
  assign wr      = bus.load_en && !busy_q;
  assign at_rest = (state_q == IDLE) || (state_q == HALT);
  assign last    = (state_q == EXEC) && !bus.stall && (cnt_q == CW'(CYCLES_PER_INSTR - 1));
  assign fetch   = (at_rest && bus.start) || last;
  assign op      = instr_q[31:26];
  assign pc4     = pc_q + 32'd4;
  assign taken   = (op == 6'h04 && bus.branch_eq) || (op == 6'h05 && !bus.branch_eq);
  assign npc     = (op == 6'h02) ? {pc_q[31:28], instr_q[25:0], 2'b00}
                 : taken ? pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00} : pc4;
  assign target  = at_rest ? RESET_PC : npc;
  assign idx     = target[ADDR_W+1:2];
  assign oor     = target[31:2] >= 30'(IMEM_DEPTH);
  // a write landing on the same edge as a start-fetch is forwarded so the fetch sees it
  assign word    = (wr && bus.load_addr == idx) ? bus.load_data : mem[idx];
  // imem has no reset; writes are blocked while busy or while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && wr) mem[bus.load_addr] <= bus.load_data;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      newinstr_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      newinstr_q <= newinstr_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end
  // next state: ISSUE always advances, EXEC counts unless stalled, fetch decides ISSUE or HALT
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    newinstr_d = 1'b0;
    busy_d     = busy_q;
    halted_d   = halted_q;
    if (fetch) begin
      pc_d       = target;
      cnt_d      = '0;
      state_d    = (oor || word[31:26] == HALT_OP) ? HALT : ISSUE;
      instr_d    = (state_d == ISSUE) ? word : instr_q;
      newinstr_d = state_d == ISSUE;
      busy_d     = state_d == ISSUE;
      halted_d   = state_d == HALT;
    end else if (state_q == ISSUE) begin
      state_d = EXEC;
      cnt_d   = CW'(1);
    end else if (state_q == EXEC && !bus.stall) begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  assign bus.instrword = instr_q;
  assign bus.newinstr  = newinstr_q;
  assign bus.pc        = pc_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
endmodule
